sn_to_bn: RTL and testbench

- Stochastic-to-binary converter sitting directly downstream of the SNG.
- Consumes the unipolar serial stochastic bit stream (o_sn_bit) over a fixed window of STREAM_LEN clocks and counts the ones.
- Emits the recovered binary value with a one-cycle valid pulse.
- Used to close the SC datapath back to binary, and as the bench checker for SNG/SC arithmetic stages.

---
 rtl/sc_pkg.sv | 15 +
 rtl/sn_ones_counter.sv | 37 +++
 rtl/sn_to_bn.sv | 134 +++++++++++++
 tb/tb_sn_to_bn.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/sc_pkg.sv
// rtl/sc_pkg.sv - shared stochastic-computing types and default widths
package sc_pkg;

  localparam int BN_WIDTH   = 4;
  localparam int STREAM_LEN = 2 ** BN_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } s2b_state_t;

  typedef logic [BN_WIDTH-1:0] bn_t;

endpackage

// File: rtl/sn_ones_counter.sv
// rtl/sn_ones_counter.sv - ones counter with synchronous clear and enable
module sn_ones_counter #(
  parameter int CNT_WIDTH = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic                 bit_i,
  output logic [CNT_WIDTH-1:0] cnt_o
);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  // Clear has priority over counting; a one is added only while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && bit_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/sn_to_bn.sv
// rtl/sn_to_bn.sv - stochastic stream to binary converter over a fixed window
module sn_to_bn
  import sc_pkg::*;
#(
  parameter int BN_WIDTH   = sc_pkg::BN_WIDTH,
  parameter int STREAM_LEN = 2 ** BN_WIDTH
) (
  input  logic                i_clk_s2b,
  input  logic                i_rst_s2b,
  input  logic                i_sn_bit,
  input  logic                i_start_s2b,
  input  logic                i_stop_s2b,
  output logic [BN_WIDTH-1:0] o_x_bn,
  output logic                o_valid_s2b,
  output logic                o_sat_s2b,
  output logic                o_busy_s2b
);

  localparam logic [BN_WIDTH-1:0] LAST_BIT = BN_WIDTH'(STREAM_LEN - 1);

  s2b_state_t state_q, state_d;

  logic [BN_WIDTH-1:0] bit_cnt_q, bit_cnt_d;
  logic [BN_WIDTH-1:0] x_q, x_d;
  logic                sat_q, sat_d;
  logic                valid_q, valid_d;

  logic                cnt_clr;
  logic                cnt_en;
  logic                load_result;
  logic [BN_WIDTH:0]   ones_cnt;
  logic [BN_WIDTH:0]   ones_final;
  logic                final_sat;
  logic [BN_WIDTH-1:0] final_x;

  sn_ones_counter #(
    .CNT_WIDTH(BN_WIDTH + 1)
  ) u_ones_counter (
    .clk_i (i_clk_s2b),
    .rst_i (i_rst_s2b),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .bit_i (i_sn_bit),
    .cnt_o (ones_cnt)
  );

  // The last bit of the window is sampled on the same edge that latches the
  // result, so fold it in here rather than waiting a cycle for the counter.
  always_comb begin
    ones_final = ones_cnt + {{BN_WIDTH{1'b0}}, i_sn_bit};
    final_sat  = ones_final[BN_WIDTH];
    final_x    = final_sat ? {BN_WIDTH{1'b1}} : ones_final[BN_WIDTH-1:0];
  end

  // Next-state logic: stop beats start everywhere; start in ACC or DONE opens
  // a fresh window on that same edge, which makes back-to-back windows gapless.
  // The result is latched on the ACC->DONE edge so valid is seen during DONE;
  // a stop sampled at the end of DONE only cancels a pending restart.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    load_result = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_start_s2b && !i_stop_s2b) begin
          state_d   = ACC;
          bit_cnt_d = '0;
          cnt_clr   = 1'b1;
        end
      end
      ACC: begin
        if (i_stop_s2b) begin
          state_d = IDLE;
        end else if (i_start_s2b) begin
          bit_cnt_d = '0;
          cnt_clr   = 1'b1;
        end else begin
          cnt_en    = 1'b1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            state_d     = DONE;
            load_result = 1'b1;
          end
        end
      end
      DONE: begin
        if (i_stop_s2b) begin
          state_d = IDLE;
        end else if (i_start_s2b) begin
          state_d   = ACC;
          bit_cnt_d = '0;
          cnt_clr   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output holding registers: x and sat only move when a window completes.
  always_comb begin
    x_d     = load_result ? final_x : x_q;
    sat_d   = load_result ? final_sat : sat_q;
    valid_d = load_result;
  end

  // State and output registers; reset aborts any window without a valid.
  always_ff @(posedge i_clk_s2b) begin
    if (i_rst_s2b) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      x_q       <= '0;
      sat_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      x_q       <= x_d;
      sat_q     <= sat_d;
      valid_q   <= valid_d;
    end
  end

  assign o_x_bn      = x_q;
  assign o_sat_s2b   = sat_q;
  assign o_valid_s2b = valid_q;
  assign o_busy_s2b  = (state_q == ACC) || (state_q == DONE);

endmodule

// File: tb/tb_sn_to_bn.sv
// tb/tb_sn_to_bn.sv - directed self-checking bench for sn_to_bn
module tb_sn_to_bn;

  logic       clk;
  logic       rst;
  logic       sn_bit;
  logic       start;
  logic       stop;
  logic [3:0] x_bn;
  logic       valid;
  logic       sat;
  logic       busy;

  int unsigned n_checks;
  int unsigned n_errors;

  sn_to_bn #(
    .BN_WIDTH  (4),
    .STREAM_LEN(16)
  ) dut (
    .i_clk_s2b  (clk),
    .i_rst_s2b  (rst),
    .i_sn_bit   (sn_bit),
    .i_start_s2b(start),
    .i_stop_s2b (stop),
    .o_x_bn     (x_bn),
    .o_valid_s2b(valid),
    .o_sat_s2b  (sat),
    .o_busy_s2b (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply inputs, take one rising edge, then sample 1ns later.
  task automatic tick(input logic r, input logic st, input logic sp, input logic b);
    rst    = r;
    start  = st;
    stop   = sp;
    sn_bit = b;
    @(posedge clk);
    #1;
  endtask

  // Start edge (bit driven high to show it is ignored) plus 16 stream bits,
  // LSB first. Counts unexpected valids and busy drops along the way.
  task automatic window(input logic [15:0] bits, output int bad);
    bad = 0;
    tick(1'b0, 1'b1, 1'b0, 1'b1);
    if (valid) bad++;
    if (!busy) bad++;
    for (int i = 0; i < 16; i++) begin
      tick(1'b0, 1'b0, 1'b0, bits[i]);
      if (i < 15 && valid) bad++;
      if (!busy) bad++;
    end
  endtask

  initial begin
    int         bad;
    int         seen;
    logic [15:0] pat;

    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    start    = 1'b0;
    stop     = 1'b0;
    sn_bit   = 1'b0;

    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    check("rst_x", x_bn, 0);
    check("rst_valid", valid, 0);
    check("rst_sat", sat, 0);
    check("rst_busy", busy, 0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);

    // 1010... pattern: 8 ones, valid right after the 16th sampled bit.
    window(16'h5555, bad);
    check("alt_bad", bad, 0);
    check("alt_valid", valid, 1);
    check("alt_x", x_bn, 8);
    check("alt_sat", sat, 0);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    check("alt_valid_pulse", valid, 0);
    check("alt_busy_idle", busy, 0);
    check("alt_x_hold", x_bn, 8);

    // Back-to-back sweep: comparator over a permuted counter gives exactly x ones.
    for (int x = 0; x < 16; x++) begin
      for (int i = 0; i < 16; i++) begin
        pat[i] = (((i * 5 + 3) % 16) < x);
      end
      window(pat, bad);
      check($sformatf("sweep_bad_%0d", x), bad, 0);
      check($sformatf("sweep_valid_%0d", x), valid, 1);
      check($sformatf("sweep_x_%0d", x), x_bn, x);
      check($sformatf("sweep_sat_%0d", x), sat, 0);
    end

    // Saturation then recovery, still back-to-back.
    window(16'hFFFF, bad);
    check("ones_bad", bad, 0);
    check("ones_valid", valid, 1);
    check("ones_x", x_bn, 15);
    check("ones_sat", sat, 1);
    window(16'h0000, bad);
    check("zeros_bad", bad, 0);
    check("zeros_valid", valid, 1);
    check("zeros_x", x_bn, 0);
    check("zeros_sat", sat, 0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);

    // Restart at cycle 9, then a 3-ones window.
    seen = 0;
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i < 9; i++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      if (valid) seen++;
    end
    window(16'h0111, bad);
    check("restart_early_valid", seen, 0);
    check("restart_bad", bad, 0);
    check("restart_valid", valid, 1);
    check("restart_x", x_bn, 3);
    tick(1'b0, 1'b0, 1'b0, 1'b0);

    // Stop after 5 ones: busy falls, no valid, x held.
    seen = 0;
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i < 6; i++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      if (valid) seen++;
    end
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    check("stop_busy", busy, 0);
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      if (valid || busy) seen++;
    end
    check("stop_no_valid", seen, 0);
    check("stop_x_hold", x_bn, 3);

    // Start and stop together: stays idle.
    seen = 0;
    tick(1'b0, 1'b1, 1'b1, 1'b1);
    check("startstop_busy", busy, 0);
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      if (valid || busy) seen++;
    end
    check("startstop_idle", seen, 0);

    // Leave x=15/sat=1, then reset at cycle 10 of a window.
    window(16'hFFFF, bad);
    check("presat_x", x_bn, 15);
    check("presat_sat", sat, 1);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i < 10; i++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b1);
    end
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    check("midrst_x", x_bn, 0);
    check("midrst_sat", sat, 0);
    check("midrst_valid", valid, 0);
    check("midrst_busy", busy, 0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      if (valid || busy) seen++;
    end
    check("midrst_quiet", seen, 0);

    // Normal conversion after reset: 7 ones.
    window(16'h007F, bad);
    check("postrst_bad", bad, 0);
    check("postrst_valid", valid, 1);
    check("postrst_x", x_bn, 7);
    check("postrst_sat", sat, 0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
